// File: rtl/hssi_mbox_pkg.sv
// Shared definitions for the HE-HSSI traffic-controller mailbox bridge.
// Covers the CSR offsets, command encodings, CMD status bit positions and FSM states.
package hssi_mbox_pkg;

  localparam logic [3:0] MB_CMD_OFFSET     = 4'h0;
  localparam logic [3:0] MB_ADDRESS_OFFSET = 4'h4;
  localparam logic [3:0] MB_RDDATA_OFFSET  = 4'h8;
  localparam logic [3:0] MB_WRDATA_OFFSET  = 4'hC;

  localparam logic [1:0] MB_NOOP = 2'b00;
  localparam logic [1:0] MB_RD   = 2'b01;
  localparam logic [1:0] MB_WR   = 2'b10;
  localparam logic [1:0] MB_BAD  = 2'b11;

  localparam int unsigned MB_ACK_BIT         = 2;
  localparam int unsigned MB_BUSY_BIT        = 3;
  localparam int unsigned MB_TIMEOUT_ERR_BIT = 4;
  localparam int unsigned MB_CMD_ERR_BIT     = 5;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StDone
  } t_mbox_state;

  function automatic logic [31:0] mb_cmd_status(input logic ack, input logic busy,
                                                input logic timeout_err, input logic cmd_err);
    logic [31:0] s;
    s                     = '0;
    s[MB_ACK_BIT]         = ack;
    s[MB_BUSY_BIT]        = busy;
    s[MB_TIMEOUT_ERR_BIT] = timeout_err;
    s[MB_CMD_ERR_BIT]     = cmd_err;
    return s;
  endfunction

endpackage

// File: rtl/hssi_mbox_timer.sv
// Per-transaction watchdog for the mailbox bridge.
// It clears on command issue, counts while enabled and flags the last allowed cycle.
module hssi_mbox_timer #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count_q;

  assign expired = en && (count_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && !expired) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hssi_mbox_avmm_bridge.sv
// Mailbox responder that turns host CMD/ADDRESS/WRDATA writes into single Avalon-MM
// transactions toward the HE-HSSI traffic controller and exposes the result in RDDATA/CMD.
module hssi_mbox_avmm_bridge
  import hssi_mbox_pkg::*;
#(
  parameter int unsigned AVMM_ADDR_W = 16,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [31:0] ERR_RDDATA  = 32'hDEAD_BEEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   csr_wr,
  input  logic                   csr_rd,
  input  logic [3:0]             csr_addr,
  input  logic [31:0]            csr_wrdata,
  output logic [31:0]            csr_rddata,
  output logic                   csr_rddata_valid,
  output logic [AVMM_ADDR_W-1:0] avmm_address,
  output logic                   avmm_read,
  output logic                   avmm_write,
  output logic [31:0]            avmm_writedata,
  input  logic [31:0]            avmm_readdata,
  input  logic                   avmm_readdatavalid,
  input  logic                   avmm_waitrequest,
  output logic                   busy
);

  t_mbox_state state_q;
  logic [31:0] address_q;
  logic [31:0] wrdata_q;
  logic [31:0] rddata_q;
  logic        ack_q;
  logic        timeout_err_q;
  logic        cmd_err_q;

  logic in_flight;
  logic cmd_accept;
  logic expired;

  assign in_flight  = (state_q == StRdReq) || (state_q == StRdWait) || (state_q == StWrReq);
  assign busy       = in_flight;
  assign cmd_accept = csr_wr && (csr_addr == MB_CMD_OFFSET) && !in_flight;

  hssi_mbox_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cmd_accept),
    .en      (in_flight),
    .expired (expired)
  );

  // ADDRESS/WRDATA are frozen while a transaction is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address_q <= '0;
      wrdata_q  <= '0;
    end else if (csr_wr && !in_flight) begin
      if (csr_addr == MB_ADDRESS_OFFSET) address_q <= csr_wrdata;
      if (csr_addr == MB_WRDATA_OFFSET)  wrdata_q  <= csr_wrdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      avmm_address   <= '0;
      avmm_read      <= 1'b0;
      avmm_write     <= 1'b0;
      avmm_writedata <= '0;
      rddata_q       <= '0;
      ack_q          <= 1'b0;
      timeout_err_q  <= 1'b0;
      cmd_err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          state_q <= StIdle;
          if (cmd_accept) begin
            ack_q         <= 1'b0;
            timeout_err_q <= 1'b0;
            cmd_err_q     <= 1'b0;
            unique case (csr_wrdata[1:0])
              MB_RD: begin
                avmm_address <= address_q[AVMM_ADDR_W-1:0];
                avmm_read    <= 1'b1;
                state_q      <= StRdReq;
              end
              MB_WR: begin
                avmm_address   <= address_q[AVMM_ADDR_W-1:0];
                avmm_writedata <= wrdata_q;
                avmm_write     <= 1'b1;
                state_q        <= StWrReq;
              end
              MB_BAD: begin
                cmd_err_q <= 1'b1;
                ack_q     <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        StRdReq: begin
          // Completion beats the watchdog when both land in the same cycle.
          if (!avmm_waitrequest && avmm_readdatavalid) begin
            rddata_q  <= avmm_readdata;
            avmm_read <= 1'b0;
            ack_q     <= 1'b1;
            state_q   <= StDone;
          end else if (expired) begin
            rddata_q      <= ERR_RDDATA;
            avmm_read     <= 1'b0;
            timeout_err_q <= 1'b1;
            ack_q         <= 1'b1;
            state_q       <= StDone;
          end else if (!avmm_waitrequest) begin
            avmm_read <= 1'b0;
            state_q   <= StRdWait;
          end
        end
        StRdWait: begin
          if (avmm_readdatavalid) begin
            rddata_q <= avmm_readdata;
            ack_q    <= 1'b1;
            state_q  <= StDone;
          end else if (expired) begin
            rddata_q      <= ERR_RDDATA;
            timeout_err_q <= 1'b1;
            ack_q         <= 1'b1;
            state_q       <= StDone;
          end
        end
        StWrReq: begin
          if (!avmm_waitrequest) begin
            avmm_write <= 1'b0;
            ack_q      <= 1'b1;
            state_q    <= StDone;
          end else if (expired) begin
            avmm_write    <= 1'b0;
            timeout_err_q <= 1'b1;
            ack_q         <= 1'b1;
            state_q       <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Reads sample the pre-write register contents, so a same-cycle write is invisible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rddata       <= '0;
      csr_rddata_valid <= 1'b0;
    end else begin
      csr_rddata_valid <= csr_rd;
      csr_rddata       <= '0;
      if (csr_rd) begin
        unique case (csr_addr)
          MB_CMD_OFFSET:     csr_rddata <= mb_cmd_status(ack_q, in_flight, timeout_err_q,
                                                         cmd_err_q);
          MB_ADDRESS_OFFSET: csr_rddata <= address_q;
          MB_RDDATA_OFFSET:  csr_rddata <= rddata_q;
          MB_WRDATA_OFFSET:  csr_rddata <= wrdata_q;
          default:           csr_rddata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hssi_mbox_avmm_bridge.sv
// Directed self-checking bench for the mailbox bridge with hand-computed expectations.
module tb_hssi_mbox_avmm_bridge;

  localparam int unsigned TO = 16;

  logic        clk;
  logic        rst_n;
  logic        csr_wr;
  logic        csr_rd;
  logic [3:0]  csr_addr;
  logic [31:0] csr_wrdata;
  logic [31:0] csr_rddata;
  logic        csr_rddata_valid;
  logic [15:0] avmm_address;
  logic        avmm_read;
  logic        avmm_write;
  logic [31:0] avmm_writedata;
  logic [31:0] avmm_readdata;
  logic        avmm_readdatavalid;
  logic        avmm_waitrequest;
  logic        busy;

  int passed = 0;
  int total  = 0;
  int rd_acc = 0;
  int wr_acc = 0;

  hssi_mbox_avmm_bridge #(
    .AVMM_ADDR_W (16),
    .TIMEOUT_CYC (TO),
    .ERR_RDDATA  (32'hDEAD_BEEF)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .csr_wr             (csr_wr),
    .csr_rd             (csr_rd),
    .csr_addr           (csr_addr),
    .csr_wrdata         (csr_wrdata),
    .csr_rddata         (csr_rddata),
    .csr_rddata_valid   (csr_rddata_valid),
    .avmm_address       (avmm_address),
    .avmm_read          (avmm_read),
    .avmm_write         (avmm_write),
    .avmm_writedata     (avmm_writedata),
    .avmm_readdata      (avmm_readdata),
    .avmm_readdatavalid (avmm_readdatavalid),
    .avmm_waitrequest   (avmm_waitrequest),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (avmm_read && !avmm_waitrequest) rd_acc++;
    if (avmm_write && !avmm_waitrequest) wr_acc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
    csr_wr     = 1'b1;
    csr_addr   = a;
    csr_wrdata = d;
    @(negedge clk);
    csr_wr     = 1'b0;
    csr_addr   = '0;
    csr_wrdata = '0;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    csr_rd   = 1'b1;
    csr_addr = a;
    @(negedge clk);
    csr_rd   = 1'b0;
    csr_addr = '0;
    chk({tag, "_vld"}, 32'(csr_rddata_valid), 32'd1);
    chk(tag, csr_rddata, exp);
  endtask

  initial begin
    int base;
    int rbase;
    int cnt;
    int guard;
    rst_n = 1'b0;
    csr_wr = 1'b0;
    csr_rd = 1'b0;
    csr_addr = '0;
    csr_wrdata = '0;
    avmm_readdata = '0;
    avmm_readdatavalid = 1'b0;
    avmm_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {28'd0, avmm_read, avmm_write, busy, csr_rddata_valid}, 32'd0);
    chk("rst_addr_out", 32'(avmm_address), 32'd0);
    chk("rst_rddata_out", csr_rddata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    read_chk("rst_cmd", 4'h0, 32'h0);
    read_chk("rst_address", 4'h4, 32'h0);
    read_chk("rst_rddata", 4'h8, 32'h0);

    // Same-cycle write and read of ADDRESS returns the old value.
    csr_wr = 1'b1; csr_rd = 1'b1; csr_addr = 4'h4; csr_wrdata = 32'h0D;
    @(negedge clk);
    csr_wr = 1'b0; csr_rd = 1'b0; csr_addr = '0; csr_wrdata = '0;
    chk("rw_same_old", csr_rddata, 32'h0);
    read_chk("address_new", 4'h4, 32'h0D);
    csr_write(4'hC, 32'h40);
    read_chk("wrdata", 4'hC, 32'h40);
    csr_write(4'h2, 32'hFFFF_FFFF);
    read_chk("unused_off", 4'h2, 32'h0);

    // Basic write with no stall.
    base = wr_acc;
    csr_write(4'h0, 32'h2);
    chk("wr_strobe", 32'(avmm_write), 32'd1);
    chk("wr_addr", 32'(avmm_address), 32'h0D);
    chk("wr_data", avmm_writedata, 32'h40);
    chk("wr_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("wr_drop", 32'(avmm_write), 32'd0);
    chk("wr_count", 32'(wr_acc - base), 32'd1);
    read_chk("wr_cmd_ack", 4'h0, 32'h4);

    // Basic read, data two cycles after accept.
    csr_write(4'h4, 32'h101);
    rbase = rd_acc;
    csr_write(4'h0, 32'h1);
    chk("rd_strobe", 32'(avmm_read), 32'd1);
    chk("rd_addr", 32'(avmm_address), 32'h101);
    @(negedge clk);
    chk("rd_wait_read", 32'(avmm_read), 32'd0);
    chk("rd_wait_busy", 32'(busy), 32'd1);
    @(negedge clk);
    avmm_readdatavalid = 1'b1; avmm_readdata = 32'h20;
    @(negedge clk);
    avmm_readdatavalid = 1'b0; avmm_readdata = '0;
    chk("rd_done_busy", 32'(busy), 32'd0);
    read_chk("rd_cmd_ack", 4'h0, 32'h4);
    read_chk("rd_rddata", 4'h8, 32'h20);
    chk("rd_count", 32'(rd_acc - rbase), 32'd1);

    // Write held off by waitrequest; a CMD write mid-flight must be ignored.
    avmm_waitrequest = 1'b1;
    csr_write(4'h4, 32'h200);
    csr_write(4'hC, 32'h1);
    base = wr_acc;
    rbase = rd_acc;
    csr_write(4'h0, 32'h2);
    for (int i = 0; i < 5; i++) begin
      chk("hold_wr", 32'(avmm_write), 32'd1);
      chk("hold_addr", 32'(avmm_address), 32'h200);
      chk("hold_data", avmm_writedata, 32'h1);
      if (i == 2) csr_write(4'h0, 32'h1);
      else @(negedge clk);
    end
    chk("hold_wr6", 32'(avmm_write), 32'd1);
    avmm_waitrequest = 1'b0;
    @(negedge clk);
    chk("hold_drop", 32'(avmm_write), 32'd0);
    chk("hold_wr_count", 32'(wr_acc - base), 32'd1);
    chk("hold_rd_count", 32'(rd_acc - rbase), 32'd0);
    read_chk("hold_cmd", 4'h0, 32'h4);

    // Read that never completes.
    avmm_waitrequest = 1'b1;
    rbase = rd_acc;
    csr_write(4'h0, 32'h1);
    cnt = 0;
    guard = 0;
    while (avmm_read && guard < 4 * TO) begin
      cnt++;
      guard++;
      @(negedge clk);
    end
    avmm_waitrequest = 1'b0;
    chk("to_read_cycles", 32'(cnt), 32'(TO));
    read_chk("to_cmd", 4'h0, 32'h14);
    read_chk("to_rddata", 4'h8, 32'hDEAD_BEEF);
    chk("to_rd_count", 32'(rd_acc - rbase), 32'd0);
    avmm_readdatavalid = 1'b1; avmm_readdata = 32'h55;
    @(negedge clk);
    avmm_readdatavalid = 1'b0; avmm_readdata = '0;
    read_chk("late_rdv", 4'h8, 32'hDEAD_BEEF);

    // Illegal encoding, then NOOP clears.
    csr_write(4'h0, 32'h3);
    chk("bad_no_avmm", {29'd0, avmm_read, avmm_write, busy}, 32'd0);
    read_chk("bad_cmd", 4'h0, 32'h24);
    csr_write(4'h0, 32'h0);
    read_chk("noop_cmd", 4'h0, 32'h0);

    // Reset during RD_WAIT.
    csr_write(4'h4, 32'h123);
    csr_write(4'h0, 32'h1);
    @(negedge clk);
    chk("prerst_busy", 32'(busy), 32'd1);
    chk("prerst_addr", 32'(avmm_address), 32'h123);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ctrl", {29'd0, avmm_read, avmm_write, busy}, 32'd0);
    chk("async_addr", 32'(avmm_address), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_chk("postrst_cmd", 4'h0, 32'h0);
    read_chk("postrst_address", 4'h4, 32'h0);

    // New read with data in the accept cycle.
    csr_write(4'h4, 32'h5);
    rbase = rd_acc;
    csr_write(4'h0, 32'h1);
    chk("rd2_strobe", 32'(avmm_read), 32'd1);
    chk("rd2_addr", 32'(avmm_address), 32'h5);
    avmm_readdatavalid = 1'b1; avmm_readdata = 32'h5A;
    @(negedge clk);
    avmm_readdatavalid = 1'b0; avmm_readdata = '0;
    chk("rd2_done", {30'd0, avmm_read, busy}, 32'd0);
    read_chk("rd2_cmd", 4'h0, 32'h4);
    read_chk("rd2_rddata", 4'h8, 32'h5A);
    chk("rd2_count", 32'(rd_acc - rbase), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
